// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the byte-serial external bus arbiter.
// Transactions walk IDLE -> ADDR0..3 -> CMD -> DATA0..3 -> DONE -> IDLE.
package ext_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR0 = 4'd1,
    ST_ADDR1 = 4'd2,
    ST_ADDR2 = 4'd3,
    ST_ADDR3 = 4'd4,
    ST_CMD   = 4'd5,
    ST_DATA0 = 4'd6,
    ST_DATA1 = 4'd7,
    ST_DATA2 = 4'd8,
    ST_DATA3 = 4'd9,
    ST_DONE  = 4'd10
  } state_e;

  localparam int   N_ADDR_BYTES = 4;
  localparam int   N_DATA_BYTES = 4;
  localparam logic CMD_WRITE    = 1'b1;
  localparam logic CMD_READ     = 1'b0;

  // Byte idx of a 32-bit word, LSB-first numbering.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    word_byte = word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ext_bus_rr_pick.sv
// Two-way round-robin picker; purely combinational so another requester
// (e.g. a DMA port) can reuse it in front of the same bus FSM.
module ext_bus_rr_pick
  import ext_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       gnt
);

  // Favour the port that did not win last time whenever both are asking.
  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing the byte-serial external memory bus between
// the instruction-fetch port (0) and the load/store port (1).
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int   NPHASE     = 10,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_oe,
  output logic        busy
);

  localparam state_e LAST_PHASE = state_e'(4'(NPHASE));

  state_e      state_r;
  state_e      state_nxt_s;
  logic        last_grant_r;
  logic        last_nxt_s;
  logic        gnt_r;
  logic        gnt_nxt_s;
  logic        we_r;
  logic        we_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] addr_nxt_s;
  logic [31:0] wdata_r;
  logic [31:0] wdata_nxt_s;
  logic [31:0] rdata_nxt_s;
  logic [7:0]  bus_addr_nxt_s;
  logic [7:0]  bus_dout_nxt_s;
  logic [7:0]  bus_oe_nxt_s;
  logic        pick_valid_s;
  logic        pick_gnt_s;
  logic [1:0]  data_idx_s;
  logic [1:0]  addr_idx_s;

  ext_bus_rr_pick u_pick (
    .req        ({req1, req0}),
    .last_grant (last_grant_r),
    .valid      (pick_valid_s),
    .gnt        (pick_gnt_s)
  );

  assign data_idx_s = 2'(state_r - ST_DATA0);
  assign addr_idx_s = 2'(state_nxt_s - ST_ADDR0);

  // Next state, request latches and read-data capture.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_grant_r;
    gnt_nxt_s   = gnt_r;
    we_nxt_s    = we_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    rdata_nxt_s = rdata;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          gnt_nxt_s   = pick_gnt_s;
          last_nxt_s  = pick_gnt_s;
          we_nxt_s    = pick_gnt_s ? we1 : we0;
          addr_nxt_s  = pick_gnt_s ? addr1 : addr0;
          wdata_nxt_s = pick_gnt_s ? wdata1 : wdata0;
          state_nxt_s = ST_ADDR0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA0, ST_DATA1, ST_DATA2, ST_DATA3: begin
        // The pins are sampled on writes too, but only reads keep the byte.
        if (we_r == CMD_READ) begin
          rdata_nxt_s[{data_idx_s, 3'b000} +: 8] = bus_din;
        end else begin
          rdata_nxt_s = rdata;
        end
        state_nxt_s = state_e'(state_r + 4'd1);
      end
      default: begin
        if (state_r >= LAST_PHASE) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_e'(state_r + 4'd1);
        end
      end
    endcase
  end

  // Pin values decoded from the state being entered, so they register in step with it.
  always_comb begin
    bus_addr_nxt_s = 8'h00;
    bus_dout_nxt_s = 8'h00;
    bus_oe_nxt_s   = 8'h00;
    case (state_nxt_s)
      ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_ADDR3: begin
        bus_addr_nxt_s = word_byte(addr_nxt_s, addr_idx_s);
        bus_dout_nxt_s = (we_nxt_s == CMD_WRITE) ? word_byte(wdata_nxt_s, addr_idx_s) : 8'h00;
        bus_oe_nxt_s   = {8{we_nxt_s == CMD_WRITE}};
      end
      ST_CMD: begin
        bus_addr_nxt_s = {7'b0000000, we_nxt_s};
        bus_dout_nxt_s = 8'h00;
        bus_oe_nxt_s   = 8'h00;
      end
      default: begin
        bus_addr_nxt_s = 8'h00;
        bus_dout_nxt_s = 8'h00;
        bus_oe_nxt_s   = 8'h00;
      end
    endcase
  end

  // State, latches and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= RESET_LAST;
      gnt_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      rdata        <= 32'h0000_0000;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      bus_addr     <= 8'h00;
      bus_dout     <= 8'h00;
      bus_oe       <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_nxt_s;
      gnt_r        <= gnt_nxt_s;
      we_r         <= we_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      rdata        <= rdata_nxt_s;
      ack0         <= (state_nxt_s == ST_DONE) && !gnt_nxt_s;
      ack1         <= (state_nxt_s == ST_DONE) && gnt_nxt_s;
      busy         <= (state_nxt_s != ST_IDLE);
      bus_addr     <= bus_addr_nxt_s;
      bus_dout     <= bus_dout_nxt_s;
      bus_oe       <= bus_oe_nxt_s;
    end
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed self-checking bench for ext_bus_arbiter: one task per scenario,
// inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_ext_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, ack0, req1, we1, ack1, busy;
  logic [31:0] addr0, wdata0, addr1, wdata1, rdata;
  logic [7:0]  bus_addr, bus_dout, bus_din, bus_oe;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ext_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_oe(bus_oe), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({ack0, ack1, busy, bus_addr, bus_dout, bus_oe, rdata} !== 59'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ack0, ack1, busy, bus_addr, bus_dout, bus_oe, rdata});
    end
    rst_n = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h000000A0; bus_din = 8'h5A;
    tick();
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b expected 1", busy); end
    rst_n = 1'b0; req0 = 1'b0;
    tick(); tick();
    n_checks++;
    if ({ack0, ack1, busy, bus_addr, bus_dout, bus_oe, rdata} !== 59'd0) begin
      n_fail++; $display("FAIL reset_abort: got %h expected 0", {ack0, ack1, busy, bus_addr, bus_dout, bus_oe, rdata});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({ack0, ack1, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_no_ack: got %b expected 000", {ack0, ack1, busy}); end
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h000000B1;
    tick();
    n_checks++;
    if (bus_addr !== 8'hA0) begin n_fail++; $display("FAIL reset_first_grant: got %h expected a0", bus_addr); end
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if ({ack0, ack1} !== 2'b10) begin n_fail++; $display("FAIL reset_first_ack: got %b expected 10", {ack0, ack1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_back_idle: got %b expected 0", busy); end
  endtask

  task automatic test_single_read();
    logic [31:0] din_w;
    din_w = 32'h44332211;
    we0 = 1'b0; addr0 = 32'h00000000; bus_din = 8'h00; req0 = 1'b1;
    for (int ph = 0; ph < 10; ph++) begin
      tick();
      n_checks++;
      if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL read_oe ph%0d: got %h expected 00", ph, bus_oe); end
      if (ph == 4) begin
        n_checks++;
        if (bus_addr !== 8'h00) begin n_fail++; $display("FAIL read_cmd: got %h expected 00", bus_addr); end
      end
      if (ph >= 5 && ph <= 8) bus_din = din_w[8*(ph-5) +: 8];
      if (ph == 8) begin
        n_checks++;
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL read_ack_early: got %b expected 0", ack0); end
      end
      if (ph == 9) begin
        n_checks++;
        if ({ack0, ack1, rdata} !== {2'b10, 32'h44332211}) begin
          n_fail++; $display("FAIL read_done: got ack=%b%b rdata=%h expected ack=10 rdata=44332211", ack0, ack1, rdata);
        end
      end
    end
    req0 = 1'b0;
    tick();
    n_checks++;
    if ({ack0, busy} !== 2'b00) begin n_fail++; $display("FAIL read_idle: got %b expected 00", {ack0, busy}); end
  endtask

  task automatic test_single_write();
    logic [7:0] exp_a [4];
    logic [7:0] exp_d [4];
    exp_a = '{8'h78, 8'h56, 8'h34, 8'h12};
    exp_d = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h12345678; wdata1 = 32'hCAFEBABE;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin addr1 = 32'hDEADBEEF; wdata1 = 32'h00000000; we1 = 1'b0; end
      n_checks++;
      if ({bus_addr, bus_dout, bus_oe} !== {exp_a[k], exp_d[k], 8'hFF}) begin
        n_fail++; $display("FAIL write_addr%0d: got a=%h d=%h oe=%h expected a=%h d=%h oe=ff", k, bus_addr, bus_dout, bus_oe, exp_a[k], exp_d[k]);
      end
    end
    tick();
    n_checks++;
    if ({bus_addr, bus_dout, bus_oe} !== {8'h01, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL write_cmd: got a=%h d=%h oe=%h expected a=01 d=00 oe=00", bus_addr, bus_dout, bus_oe);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({bus_oe, ack0, ack1} !== 10'd0) begin
        n_fail++; $display("FAIL write_data%0d: got oe=%h ack=%b%b expected oe=00 ack=00", k, bus_oe, ack0, ack1);
      end
    end
    tick();
    n_checks++;
    if ({ack0, ack1, busy} !== 3'b011) begin n_fail++; $display("FAIL write_done: got %b expected 011", {ack0, ack1, busy}); end
    req1 = 1'b0;
    tick();
    n_checks++;
    if ({ack1, busy} !== 2'b00) begin n_fail++; $display("FAIL write_idle: got %b expected 00", {ack1, busy}); end
  endtask

  task automatic test_contention();
    logic       g;
    logic [7:0] exp_b;
    we0 = 1'b0; we1 = 1'b0; addr0 = 32'h000000A0; addr1 = 32'h000000B1; bus_din = 8'h00;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = t[0];
      exp_b = g ? 8'hB1 : 8'hA0;
      tick();
      n_checks++;
      if (bus_addr !== exp_b) begin n_fail++; $display("FAIL contention_grant%0d: got %h expected %h", t, bus_addr, exp_b); end
      for (int i = 0; i < 9; i++) tick();
      n_checks++;
      if ({ack1, ack0} !== (g ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_ack%0d: got ack1,ack0=%b%b expected port %0d", t, ack1, ack0, g);
      end
      if (g) req1 = 1'b0; else req0 = 1'b0;
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL contention_gap%0d: got busy=%b expected 0", t, busy); end
      if (t < 3) begin if (g) req1 = 1'b1; else req0 = 1'b1; end
    end
  endtask

  task automatic test_early_drop();
    int n_ack;
    n_ack = 0;
    we0 = 1'b0; addr0 = 32'h000000C0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    n_checks++;
    if (bus_addr !== 8'hC0) begin n_fail++; $display("FAIL drop_grant: got %h expected c0", bus_addr); end
    for (int i = 1; i < 10; i++) begin
      tick();
      if (ack0 === 1'b1) n_ack++;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy%0d: got %b expected 1", i, busy); end
    end
    n_checks++;
    if (ack0 !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %b expected 1", ack0); end
    tick();
    if (ack0 === 1'b1) n_ack++;
    tick();
    if (ack0 === 1'b1) n_ack++;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b expected 0", busy); end
    n_checks++;
    if (n_ack != 1) begin n_fail++; $display("FAIL drop_ack_count: got %0d expected 1", n_ack); end
  endtask

  task automatic test_write_rdata_hold();
    we0 = 1'b0; addr0 = 32'h00000040; bus_din = 8'hA5; req0 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if ({ack0, rdata} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL hold_read: got ack0=%b rdata=%h expected ack0=1 rdata=a5a5a5a5", ack0, rdata);
    end
    req0 = 1'b0;
    tick();
    bus_din = 8'hFF; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h00000010; wdata1 = 32'h01020304;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if ({ack1, rdata} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL hold_write: got ack1=%b rdata=%h expected ack1=1 rdata=a5a5a5a5", ack1, rdata);
    end
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0; bus_din = 8'h00;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_early_drop();
    test_write_rdata_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1, "timeout");
  end

endmodule
